imm_gen_stage: RTL and testbench
================================

# imm_gen_stage

Registered immediate-generation and field-extract stage between instruction fetch and the register-file read in the NPC core. Classifies each 32-bit instruction into a format, produces the sign- or zero-extended immediate at XLEN bits for all six base formats plus CSR-immediate, and flags illegal opcodes and RV32E register violations. It replaces the single-cycle combinational extender with a valid/ready stage backed by a two-entry skid buffer, so downstream stalls never create a combinational ready path to fetch. A `flush` input discards everything in flight for branch redirects.

## Interface
- `XLEN`, 32 — immediate/PC width; 32 or 64.
- `RVE`, 1 — 1: register index ≥16 in a used field sets `illegal`.
- `clk` input 1 — clock.
- `rst` input 1 — reset; one clock, synchronous, active-high.
- `flush` input 1 — discard all buffered entries.
- `in_valid` input 1 — `inst`/`pc` valid.
- `in_ready` output 1 — stage can accept; registered.
- `inst` input 32 — instruction word.
- `pc` input XLEN — instruction address, passed through.
- `out_valid` output 1 — output fields valid.
- `out_ready` input 1 — consumer accepts.
- `out_pc` output XLEN — passed-through PC.
- `out_type` output `TYPE_BUS` — format code (R/I/S/B/U/J/CSRI/ILL).
- `out_imm` output XLEN — extended immediate.
- `out_rs1`, `out_rs2`, `out_rd` output 5 each — `inst[19:15]`, `inst[24:20]`, `inst[11:7]`.
- `out_illegal` output 1 — unknown opcode or RVE violation.

## Operation
- Format by opcode:
  - 0110011 → R.
  - 0010011/0000011/1100111 → I.
  - 1110011 → I, or CSRI when `funct3[2]`=1.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111/0010111 → U.
  - 1101111 → J.
  - anything else → ILL with `illegal`=1.
- Immediates (sext = sign-extend to XLEN):
  - I: sext(inst[31:20]).
  - S: sext({inst[31:25],inst[11:7]}).
  - B: sext({inst[31],inst[7],inst[30:25],inst[11:8],0}).
  - U: sext({inst[31:12],12'b0}).
  - J: sext({inst[31],inst[19:12],inst[20],inst[30:21],0}).
  - CSRI: zero-extended inst[19:15].
  - R and ILL: 0.
- RVE check, only on fields the format uses:
  - rd for R/I/U/J/CSRI.
  - rs1 for R/I/S/B.
  - rs2 for R/S/B.
  - Any used index with bit 4 set → `illegal`=1; type is kept.
- Decode is combinational on the input side. The results are captured into the buffer; outputs come from the head entry only.
- Buffer state machine, states EMPTY / ONE / FULL:
  - EMPTY: input fire → ONE.
  - ONE:
    - fire in and out → ONE.
    - in only → FULL (entry goes to skid slot).
    - out only → EMPTY.
  - FULL: out fire → ONE; skid entry moves to head.
- `in_ready` = state≠FULL, taken from the registered state.
- `out_valid` = state≠EMPTY.
- Order is strictly FIFO.

## Timing
- Latency: an input accepted at edge N appears at the outputs after edge N (same-cycle visibility is forbidden).
- Throughput: 1 instruction per cycle while `out_ready`=1.
- Fire rules: input fire = `in_valid & in_ready`; output fire = `out_valid & out_ready`. `out_*` fields hold stable while `out_valid & !out_ready`.
- Reset: state EMPTY; `out_valid`=0, `in_ready`=1; all `out_*` data fields 0. Reset mid-transfer drops all entries.
- `flush`:
  - Next state EMPTY, `in_ready`=1.
  - An input firing in the same cycle is discarded.
  - The output fire in that cycle still counts as consumed.
  - `rst` has priority over `flush`.
- FULL with `out_ready`=1 and `in_valid`=1: `in_ready` is 0, so only the output drains; the state goes to ONE and the input is accepted next cycle.

## Structure
- Shared `defines.v`:
  - format codes `INST_R/I/S/B/U/J` plus new `INST_CSRI`, `INST_ILL`;
  - `TYPE_BUS`;
  - opcode constants `OP_*`.
- Sub-module `imm_decode`: combinational; `inst` → {type, imm, illegal}; parametrised by XLEN and RVE.
- The top level holds the 2-entry buffer and its state machine.

## Test plan
- `0xFFF00093` (addi x1,x0,-1) → type I, imm `0xFFFFFFFF`, rd 1, illegal 0, valid one cycle after accept.
- `0xFE000EE3` (beq -4) → type B, imm `0xFFFFFFFC`. `0x123452B7` (lui x5) → imm `0x12345000`. `0x001000EF` (jal x1,2048) → imm `0x00000800`. With XLEN=64, `0x800002B7` → imm `0xFFFFFFFF80000000`.
- `out_ready`=0 while three back-to-back inputs are offered → two accepted, `in_ready`=0 from cycle 2; release `out_ready` → outputs in order, third accepted one cycle later, no loss or duplicate.
- `flush` while FULL with `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, flushed input never appears.
- RVE=1: `0x01080833` (add x16,x16,x16) → `illegal`=1, type R. RVE=0 → `illegal`=0. Opcode `0x7F` → type ILL, imm 0, `illegal`=1.
- `rst` asserted while FULL → next cycle `out_valid`=0, `in_ready`=1, all data outputs 0.

Source files
------------

// File: rtl/imm_gen_stage_pkg.sv
// Shared types for the immediate-generation stage:
// format codes, opcodes and buffer states.
package imm_gen_stage_pkg;

  localparam int TYPE_W = 3;

  typedef enum logic [TYPE_W-1:0] {
    INST_R    = 3'd0,
    INST_I    = 3'd1,
    INST_S    = 3'd2,
    INST_B    = 3'd3,
    INST_U    = 3'd4,
    INST_J    = 3'd5,
    INST_CSRI = 3'd6,
    INST_ILL  = 3'd7
  } inst_type_e;

  typedef logic [TYPE_W-1:0] type_bus_t;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational format classifier and immediate
// extender with optional RV32E register check.
module imm_decode
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit RVE  = 1'b1
) (
  input  logic [31:0]     inst,
  output inst_type_e      inst_type,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [6:0] opcode;
  logic       use_rd;
  logic       use_rs1;
  logic       use_rs2;
  logic       rve_bad;

  assign opcode = inst[6:0];

  always_comb begin
    inst_type = INST_ILL;
    unique case (1'b1)
      opcode == OP_OP:     inst_type = INST_R;
      opcode == OP_IMM,
      opcode == OP_LOAD,
      opcode == OP_JALR:   inst_type = INST_I;
      opcode == OP_SYSTEM:
        inst_type = inst[14] ? INST_CSRI : INST_I;
      opcode == OP_STORE:  inst_type = INST_S;
      opcode == OP_BRANCH: inst_type = INST_B;
      opcode == OP_LUI,
      opcode == OP_AUIPC:  inst_type = INST_U;
      opcode == OP_JAL:    inst_type = INST_J;
      default:             inst_type = INST_ILL;
    endcase
  end

  always_comb begin
    imm = '0;
    unique case (inst_type)
      INST_I:
        imm = XLEN'($signed(inst[31:20]));
      INST_S:
        imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      INST_B:
        imm = XLEN'($signed({inst[31], inst[7],
                inst[30:25], inst[11:8], 1'b0}));
      INST_U:
        imm = XLEN'($signed({inst[31:12], 12'b0}));
      INST_J:
        imm = XLEN'($signed({inst[31], inst[19:12],
                inst[20], inst[30:21], 1'b0}));
      INST_CSRI:
        imm = XLEN'(inst[19:15]);
      default:
        imm = '0;
    endcase
  end

  // CSRI rs1 field carries the zimm, not a register
  always_comb begin
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    unique case (inst_type)
      INST_R: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      INST_I: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
      end
      INST_S, INST_B: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      INST_U, INST_J, INST_CSRI:
        use_rd = 1'b1;
      default: ;
    endcase
  end

  assign rve_bad = RVE &&
    ((use_rd  && inst[11]) ||
     (use_rs1 && inst[19]) ||
     (use_rs2 && inst[24]));

  assign illegal = (inst_type == INST_ILL) || rve_bad;

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decode on
// input, two-entry skid buffer toward the consumer.
module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit RVE  = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output inst_type_e      out_type,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    inst_type_e      ty;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            illegal;
  } entry_t;

  entry_t     dec;
  entry_t     head;
  entry_t     skid;
  buf_state_e state;
  logic       in_fire;
  logic       out_fire;

  imm_decode #(
    .XLEN (XLEN),
    .RVE  (RVE)
  ) u_dec (
    .inst      (inst),
    .inst_type (dec.ty),
    .imm       (dec.imm),
    .illegal   (dec.illegal)
  );

  assign dec.pc  = pc;
  assign dec.rs1 = inst[19:15];
  assign dec.rs2 = inst[24:20];
  assign dec.rd  = inst[11:7];

  // Handshake flags depend only on registered state
  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
      head  <= '0;
      skid  <= '0;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            head  <= dec;
            state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            head <= dec;
          end else if (in_fire) begin
            skid  <= dec;
            state <= ST_FULL;
          end else if (out_fire) begin
            state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            head  <= skid;
            state <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  assign out_pc      = head.pc;
  assign out_type    = head.ty;
  assign out_imm     = head.imm;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_rd      = head.rd;
  assign out_illegal = head.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed self-checking bench for imm_gen_stage
// (RV32E, RV32I and RV64E instances in lockstep).
module tb_imm_gen_stage;
  import imm_gen_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [63:0] pc64;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_ill;
  logic [31:0] a_pc, a_imm;
  inst_type_e  a_type;
  logic [4:0]  a_rs1, a_rs2, a_rd;

  logic        b_in_ready, b_out_valid, b_ill;
  logic [31:0] b_pc, b_imm;
  inst_type_e  b_type;
  logic [4:0]  b_rs1, b_rs2, b_rd;

  logic        c_in_ready, c_out_valid, c_ill;
  logic [63:0] c_pc, c_imm;
  inst_type_e  c_type;
  logic [4:0]  c_rs1, c_rs2, c_rd;

  int n_checks = 0;
  int n_errors = 0;

  assign pc64 = {32'h0, pc};

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .RVE(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .inst(inst), .pc(pc),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_type(a_type),
    .out_imm(a_imm), .out_rs1(a_rs1),
    .out_rs2(a_rs2), .out_rd(a_rd),
    .out_illegal(a_ill)
  );

  imm_gen_stage #(.XLEN(32), .RVE(1'b0)) dut_i (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .inst(inst), .pc(pc),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_type(b_type),
    .out_imm(b_imm), .out_rs1(b_rs1),
    .out_rs2(b_rs2), .out_rd(b_rd),
    .out_illegal(b_ill)
  );

  imm_gen_stage #(.XLEN(64), .RVE(1'b1)) dut_64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(c_in_ready),
    .inst(inst), .pc(pc64),
    .out_valid(c_out_valid), .out_ready(out_ready),
    .out_pc(c_pc), .out_type(c_type),
    .out_imm(c_imm), .out_rs1(c_rs1),
    .out_rs2(c_rs2), .out_rd(c_rd),
    .out_illegal(c_ill)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    inst = '0; pc = '0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_hs: valid=%b ready=%b want 0 1",
        a_out_valid, a_in_ready);
    end
    n_checks++;
    if ({a_pc, a_imm, a_type, a_rs1, a_rs2, a_rd, a_ill}
        !== '0) begin
      n_errors++;
      $display("FAIL reset_data: pc=%h imm=%h want 0",
        a_pc, a_imm);
    end
  endtask

  task automatic test_formats();
    logic [31:0] vi [9] = '{
      32'hFFF00093, 32'hFE000EE3, 32'h123452B7,
      32'h001000EF, 32'hFE112E23, 32'h3002D0F3,
      32'h0000007F, 32'h01080833, 32'h800002B7};
    inst_type_e  vt [9] = '{
      INST_I, INST_B, INST_U, INST_J, INST_S,
      INST_CSRI, INST_ILL, INST_R, INST_U};
    logic [31:0] vm [9] = '{
      32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000,
      32'h00000800, 32'hFFFFFFFC, 32'h00000005,
      32'h00000000, 32'h00000000, 32'h80000000};
    logic [4:0]  vr [9] = '{
      5'd1, 5'd29, 5'd5, 5'd1, 5'd28,
      5'd1, 5'd0, 5'd16, 5'd5};
    logic        vl [9] = '{
      1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
      1'b0, 1'b1, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      inst = vi[i];
      pc = 32'h1000 + 32'(i * 4);
      in_valid = 1'b1;
      n_checks++;
      if (a_out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL early_valid[%0d]: got %b want 0",
          i, a_out_valid);
      end
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (a_out_valid !== 1'b1 || a_type !== vt[i] ||
          a_imm !== vm[i] || a_rd !== vr[i] ||
          a_ill !== vl[i] ||
          a_pc !== 32'h1000 + 32'(i * 4)) begin
        n_errors++;
        $display("FAIL fmt[%0d]: v=%b t=%0d imm=%h rd=%0d ill=%b pc=%h want 1 %0d %h %0d %b",
          i, a_out_valid, a_type, a_imm, a_rd, a_ill,
          a_pc, vt[i], vm[i], vr[i], vl[i]);
      end
      if (i == 7) begin
        n_checks++;
        if (b_ill !== 1'b0 || b_type !== INST_R) begin
          n_errors++;
          $display("FAIL rv32i_add16: ill=%b t=%0d want 0 0",
            b_ill, b_type);
        end
      end
      if (i == 0) begin
        n_checks++;
        if (c_imm !== 64'hFFFFFFFFFFFFFFFF) begin
          n_errors++;
          $display("FAIL x64_addi: got %h want all ones",
            c_imm);
        end
      end
      if (i == 8) begin
        n_checks++;
        if (c_imm !== 64'hFFFFFFFF80000000 ||
            c_type !== INST_U) begin
          n_errors++;
          $display("FAIL x64_lui: imm=%h t=%0d want ffffffff80000000 4",
            c_imm, c_type);
        end
      end
      tick();
    end
  endtask

  task automatic test_throughput();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inst = 32'h00000013;
      pc = 32'h2000 + 32'(i * 4);
      tick();
      n_checks++;
      if (a_out_valid !== 1'b1 || a_in_ready !== 1'b1 ||
          a_pc !== 32'h2000 + 32'(i * 4)) begin
        n_errors++;
        $display("FAIL stream[%0d]: v=%b r=%b pc=%h want pc %h",
          i, a_out_valid, a_in_ready, a_pc,
          32'h2000 + 32'(i * 4));
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (a_out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL stream_drain: v=%b want 0", a_out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1;
    inst = 32'h00100093; pc = 32'h3000;
    tick();
    n_checks++;
    if (a_in_ready !== 1'b1 || a_pc !== 32'h3000) begin
      n_errors++;
      $display("FAIL bb_one: r=%b pc=%h want 1 3000",
        a_in_ready, a_pc);
    end
    inst = 32'h00200113; pc = 32'h3004;
    tick();
    n_checks++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL bb_full: r=%b v=%b want 0 1",
        a_in_ready, a_out_valid);
    end
    inst = 32'h00300193; pc = 32'h3008;
    tick();
    n_checks++;
    if (a_in_ready !== 1'b0 || a_pc !== 32'h3000 ||
        a_rd !== 5'd1) begin
      n_errors++;
      $display("FAIL bb_hold: r=%b pc=%h rd=%0d want 0 3000 1",
        a_in_ready, a_pc, a_rd);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (a_pc !== 32'h3004 || a_rd !== 5'd2 ||
        a_in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL bb_second: pc=%h rd=%0d r=%b want 3004 2 1",
        a_pc, a_rd, a_in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (a_pc !== 32'h3008 || a_rd !== 5'd3 ||
        a_out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL bb_third: pc=%h rd=%0d v=%b want 3008 3 1",
        a_pc, a_rd, a_out_valid);
    end
    tick();
    n_checks++;
    if (a_out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL bb_dup: v=%b pc=%h want 0",
        a_out_valid, a_pc);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1;
    inst = 32'h00100093; pc = 32'h4000;
    tick();
    pc = 32'h4004;
    tick();
    pc = 32'h4008;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_full: v=%b r=%b want 0 1",
        a_out_valid, a_in_ready);
    end
    tick();
    n_checks++;
    if (a_out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_ghost: v=%b pc=%h want 0",
        a_out_valid, a_pc);
    end
    in_valid = 1'b1; pc = 32'h4010;
    tick();
    pc = 32'h4014;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_one: v=%b r=%b pc=%h want 0 1",
        a_out_valid, a_in_ready, a_pc);
    end
  endtask

  task automatic test_rst_full();
    out_ready = 1'b0;
    in_valid = 1'b1;
    inst = 32'hFFF00093; pc = 32'h5000;
    tick();
    pc = 32'h5004;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (a_in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_pre: r=%b want 0", a_in_ready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 ||
        a_pc !== '0 || a_imm !== '0 || a_rd !== '0 ||
        a_type !== INST_R || a_ill !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_full: v=%b r=%b pc=%h imm=%h rd=%0d want 0 1 0 0 0",
        a_out_valid, a_in_ready, a_pc, a_imm, a_rd);
    end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_throughput();
    test_back_to_back();
    test_flush();
    test_rst_full();
    $display("Simulation finished: %0d checks, %0d errors",
      n_checks, n_errors);
    $finish;
  end

endmodule
